// File: rtl/jmb_scanline_window_buffer.sv
// 3x3 sliding window over a raster pixel stream, two line buffers deep.
// Emits one registered neighbourhood per completing write; tracks frame position.
module jmb_scanline_window_buffer #(
   parameter int MAX_WIDTH = 2048,
   parameter int ADDR_W    = 11
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  pixel_in,
   input  logic        pixel_wr,
   input  logic        pixel_filter,
   input  logic [31:0] width,
   input  logic [31:0] height,
   output logic [71:0] window_out,
   output logic [31:0] window_x,
   output logic [31:0] window_y,
   output logic        window_filter,
   output logic        window_valid,
   output logic        frame_done,
   output logic        config_error
);

   logic [31:0] width_r;
   logic [31:0] height_r;
   logic [31:0] x_cnt;
   logic [31:0] y_cnt;

   logic [7:0] lb0 [0:MAX_WIDTH-1];
   logic [7:0] lb1 [0:MAX_WIDTH-1];

   logic [ADDR_W-1:0] addr;
   logic [7:0]        top_rd;
   logic [7:0]        mid_rd;

   // columns packed as {top, mid, bottom}; col0 is the leftmost
   logic [23:0] col0;
   logic [23:0] col1;
   logic [23:0] col2;

   logic last_x;
   logic last_y;
   logic win_ok;
   logic cfg_idle;

   assign addr   = x_cnt[ADDR_W-1:0];
   assign top_rd = lb1[addr];
   assign mid_rd = lb0[addr];

   assign last_x   = (x_cnt == width_r - 32'd1);
   assign last_y   = (y_cnt == height_r - 32'd1);
   assign win_ok   = (x_cnt >= 32'd2) && (y_cnt >= 32'd2);
   assign cfg_idle = (x_cnt == 32'd0) && (y_cnt == 32'd0) && !pixel_wr;

   assign config_error = (width_r < 32'd3)
                      || (width_r > 32'(MAX_WIDTH))
                      || (height_r < 32'd3);

   assign window_out = {col0[23:16], col1[23:16], col2[23:16],
                        col0[15:8],  col1[15:8],  col2[15:8],
                        col0[7:0],   col1[7:0],   col2[7:0]};

   // line buffer storage is deliberately unreset; reads are read-first
   always_ff @(posedge clock) begin
      if (pixel_wr) begin
         lb1[addr] <= mid_rd;
         lb0[addr] <= pixel_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         width_r  <= '0;
         height_r <= '0;
      end else if (cfg_idle) begin
         width_r  <= width;
         height_r <= height;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_cnt      <= '0;
         y_cnt      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pixel_wr) begin
            if (last_x) begin
               x_cnt <= '0;
               if (last_y) begin
                  y_cnt      <= '0;
                  frame_done <= 1'b1;
               end else begin
                  y_cnt <= y_cnt + 32'd1;
               end
            end else begin
               x_cnt <= x_cnt + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col0          <= '0;
         col1          <= '0;
         col2          <= '0;
         window_x      <= '0;
         window_y      <= '0;
         window_filter <= 1'b0;
         window_valid  <= 1'b0;
      end else begin
         window_valid <= 1'b0;
         if (pixel_wr) begin
            col0 <= col1;
            col1 <= col2;
            col2 <= {top_rd, mid_rd, pixel_in};
            if (win_ok) begin
               window_x      <= x_cnt - 32'd1;
               window_y      <= y_cnt - 32'd1;
               window_filter <= pixel_filter;
               window_valid  <= !config_error;
            end
         end
      end
   end

endmodule
